fpu_link_host: RTL and testbench

FPU_LINK_HOST -- requirements
Module: fpu_link_host

---
 rtl/fpu_link_host.sv | 98 +++++++++
 tb/tb_fpu_link_host.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_link_host.sv
// Host side of the FPU pin link: sends A, B and OP as a three-word strobed frame,
// then waits for the chip's done/result reply, with a bounded timeout.
module fpu_link_host #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_a,
  input  logic [9:0]  req_b,
  input  logic [3:0]  req_op,
  output logic [11:0] pin_out,
  input  logic [11:0] pin_in,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [9:0]  resp_data,
  output logic        resp_err
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_OP, WAIT, RESP} state_t;

  localparam logic [9:0] LAST_COUNT = 10'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [9:0] b_q;
  logic [3:0] op_q;
  logic [9:0] wait_cnt;
  logic       done;
  logic       timed_out;
  logic       unused_pin_in;

  assign done          = pin_in[0];
  assign unused_pin_in = pin_in[1];
  assign timed_out     = !done && (wait_cnt == LAST_COUNT);
  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = SEND_A;
      SEND_A:  next_state = SEND_B;
      SEND_B:  next_state = SEND_OP;
      SEND_OP: next_state = WAIT;
      WAIT:    if (done || timed_out) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // pin_out is loaded from the state being entered, so each frame word is
  // on the bus for exactly the cycle its state is active; A goes straight
  // from the request port on the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_q       <= '0;
      op_q      <= '0;
      pin_out   <= '0;
      wait_cnt  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        b_q  <= req_b;
        op_q <= req_op;
      end

      case (next_state)
        SEND_A:  pin_out <= {2'b10, req_a};
        SEND_B:  pin_out <= {2'b10, b_q};
        SEND_OP: pin_out <= {2'b11, 6'b0, op_q};
        default: pin_out <= '0;
      endcase

      if (state == WAIT && !done && !timed_out) wait_cnt <= wait_cnt + 10'd1;
      else                                      wait_cnt <= '0;

      // done takes priority over a timeout landing in the same cycle
      if (state == WAIT) begin
        if (done) begin
          resp_data <= pin_in[11:2];
          resp_err  <= 1'b0;
        end else if (timed_out) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_link_host.sv
// Randomized scoreboard bench for fpu_link_host: stimulus pushes expected frame
// words and responses, a negedge monitor pops and compares what the DUT presents.
module tb_fpu_link_host;

  localparam int TIMEOUT_P = 4;

  typedef struct {
    logic [9:0] data;
    logic       err;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_a;
  logic [9:0]  req_b;
  logic [3:0]  req_op;
  logic [11:0] pin_out;
  logic [11:0] pin_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [9:0]  resp_data;
  logic        resp_err;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] frame_q[$];
  resp_t       resp_q[$];
  int          frame_idx = 0;
  logic [11:0] exp_word;
  resp_t       exp_resp;

  fpu_link_host #(.TIMEOUT(TIMEOUT_P)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .pin_out    (pin_out),
    .pin_in     (pin_in),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] chipNoise(input bit done_bit);
    return {10'($urandom), 1'($urandom), done_bit};
  endfunction

  // Scoreboard monitor: a frame is three consecutive words, responses are
  // compared every cycle they are shown and retired on the handshake.
  always @(negedge clock) begin
    if (reset) begin
      frame_q.delete();
      resp_q.delete();
      frame_idx = 0;
    end else begin
      if (pin_out != 12'h000 || frame_idx != 0) begin
        if (frame_q.size() == 0) begin
          checkOutput("frame_unexpected", 32'(pin_out), 32'h000);
        end else begin
          exp_word = frame_q.pop_front();
          checkOutput("frame_word", 32'(pin_out), 32'(exp_word));
        end
        frame_idx = (frame_idx + 1) % 3;
      end
      if (resp_valid) begin
        checkOutput("req_ready_while_resp", 32'(req_ready), 32'h0);
        if (resp_q.size() == 0) begin
          checkOutput("resp_unexpected", 32'(resp_valid), 32'h0);
        end else begin
          exp_resp = resp_q[0];
          checkOutput("resp_data", 32'(resp_data), 32'(exp_resp.data));
          checkOutput("resp_err", 32'(resp_err), 32'(exp_resp.err));
          if (resp_ready) void'(resp_q.pop_front());
        end
      end
    end
  end

  task automatic waitReady();
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    checkOutput("req_ready_before_offer", 32'(req_ready), 32'h1);
  endtask

  // k = WAIT cycle (1-based) on which the chip raises done; 0 means never.
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic [3:0] op,
                               input int k, input logic [9:0] result, input bit stale,
                               input int hold);
    resp_t r;
    bit    done_ok;
    int    lat;
    int    c;
    done_ok = (k >= 1) && (k <= TIMEOUT_P);
    r.data  = done_ok ? result : 10'h000;
    r.err   = !done_ok;
    lat     = 3 + (done_ok ? k : TIMEOUT_P);

    waitReady();
    frame_q.push_back({2'b10, a});
    frame_q.push_back({2'b10, b});
    frame_q.push_back({2'b11, 6'b0, op});
    resp_q.push_back(r);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    pin_in    = chipNoise(stale);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_a     = 10'($urandom);
    req_b     = 10'($urandom);
    req_op    = 4'($urandom);
    pin_in    = chipNoise(stale);

    c = 0;
    while (!resp_valid && c < 40) begin
      @(posedge clock); #1;
      c++;
      if (c < 3)           pin_in = chipNoise(stale);
      else if (c - 2 == k) pin_in = {result, 1'($urandom), 1'b1};
      else                 pin_in = chipNoise(1'b0);
    end
    checkOutput("latency", 32'(c), 32'(lat));

    pin_in = chipNoise(1'($urandom));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = 10'($urandom);
      req_b     = 10'($urandom);
      req_op    = 4'($urandom);
      @(posedge clock); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    pin_in     = 12'h000;
    checkOutput("resp_valid_after_take", 32'(resp_valid), 32'h0);
    checkOutput("req_ready_after_take", 32'(req_ready), 32'h1);
  endtask

  task automatic resetMidFrame(input logic [9:0] a, input logic [9:0] b, input logic [3:0] op);
    waitReady();
    frame_q.push_back({2'b10, a});
    frame_q.push_back({2'b10, b});
    frame_q.push_back({2'b11, 6'b0, op});
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_pin_out", 32'(pin_out), 32'h000);
    checkOutput("midreset_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("midreset_resp_data", 32'(resp_data), 32'h000);
    checkOutput("midreset_resp_err", 32'(resp_err), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready_after_midreset", 32'(req_ready), 32'h1);
    checkOutput("pin_out_after_midreset", 32'(pin_out), 32'h000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    pin_in     = 12'h000;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_pin_out", 32'(pin_out), 32'h000);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset_resp_data", 32'(resp_data), 32'h000);
    checkOutput("reset_resp_err", 32'(resp_err), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready_after_reset", 32'(req_ready), 32'h1);

    applyStimulus(10'h155, 10'h0AA, 4'h3, 2, 10'h3FF, 1'b0, 10);
    applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), 0, 10'($urandom), 1'b0, 0);
    applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), TIMEOUT_P, 10'($urandom), 1'b0, 3);
    applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), 1, 10'($urandom), 1'b1, 1);
    applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), TIMEOUT_P + 1, 10'($urandom), 1'b0, 2);
    applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), 3, 10'($urandom), 1'b1, 0);
    resetMidFrame(10'h2C3, 10'h13C, 4'hA);
    applyStimulus(10'h201, 10'h102, 4'h9, 1, 10'h0F0, 1'b0, 0);

    for (int n = 0; n < 25; n++) begin
      applyStimulus(10'($urandom), 10'($urandom), 4'($urandom), $urandom_range(0, 6),
                    10'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    repeat (3) @(posedge clock);
    #1;
    checkOutput("frame_queue_drained", 32'(frame_q.size()), 32'h0);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
